// File: rtl/somador4_bist.sv
// Built-in self-test controller for the somador4 4-bit adder: walks all 512 {A,B,CIN}
// vectors, checks {S,COUT} against A+B+CIN and counts per-field mismatches.
module somador4_bist #(
    parameter int unsigned SETTLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [3:0]  A_o,
    output logic [3:0]  B_o,
    output logic        CIN_o,
    input  logic [3:0]  S_i,
    input  logic        COUT_i,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [10:0] erros,
    output logic [9:0]  vec_ind,
    output logic        err_valid,
    output logic [13:0] err_vec
);

    typedef enum logic [1:0] {StIdle, StWait, StCheck, StDone} state_e;

    localparam logic [3:0] CntLoad = 4'(SETTLE - 1);

    state_e      state_q;
    logic [8:0]  vec_q;
    logic [3:0]  cnt_q;
    logic        busy_q;
    logic        done_q;
    logic        err_valid_q;
    logic [10:0] erros_q;
    logic [9:0]  vec_ind_q;
    logic [13:0] err_vec_q;

    logic [4:0]  exp_sum;
    logic        s_bad;
    logic        c_bad;
    logic [10:0] err_inc;

    // Case-inequality so that unknown responses count as mismatches in simulation.
    always_comb begin
        exp_sum = {1'b0, vec_q[8:5]} + {1'b0, vec_q[4:1]} + {4'b0000, vec_q[0]};
        s_bad   = (S_i !== exp_sum[3:0]);
        c_bad   = (COUT_i !== exp_sum[4]);
        err_inc = {10'd0, s_bad} + {10'd0, c_bad};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            vec_q       <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_valid_q <= 1'b0;
            erros_q     <= '0;
            vec_ind_q   <= '0;
            err_vec_q   <= '0;
        end else begin
            err_valid_q <= 1'b0;
            case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        state_q   <= StWait;
                        vec_q     <= '0;
                        cnt_q     <= CntLoad;
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                        erros_q   <= '0;
                        vec_ind_q <= '0;
                    end
                end
                StWait: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= StCheck;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StCheck: begin
                    erros_q   <= erros_q + err_inc;
                    vec_ind_q <= vec_ind_q + 10'd1;
                    if (s_bad || c_bad) begin
                        err_valid_q <= 1'b1;
                        err_vec_q   <= {vec_q, S_i, COUT_i};
                    end
                    // The final vector stays on the outputs while in DONE.
                    if (vec_q == 9'd511) begin
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        vec_q   <= vec_q + 9'd1;
                        cnt_q   <= CntLoad;
                        state_q <= StWait;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign A_o       = vec_q[8:5];
    assign B_o       = vec_q[4:1];
    assign CIN_o     = vec_q[0];
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = done_q && (erros_q == 11'd0);
    assign erros     = erros_q;
    assign vec_ind   = vec_ind_q;
    assign err_valid = err_valid_q;
    assign err_vec   = err_vec_q;

endmodule

// File: tb/tb_somador4_bist.sv
// Bench for somador4_bist: a behavioural adder with selectable faults drives the responses and
// a vector-enumerating model predicts error counts and the ordered list of failing vectors.
module tb_somador4_bist;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // SETTLE=1 instance
    logic        rst1, start1, c1, co1, busy1, done1, pass1, ev1;
    logic [3:0]  a1, b1, s1;
    logic [10:0] erros1;
    logic [9:0]  vind1;
    logic [13:0] evec1;
    // SETTLE=3 instance
    logic        rst3, start3, c3, co3, busy3, done3, pass3, ev3;
    logic [3:0]  a3, b3, s3;
    logic [10:0] erros3;
    logic [9:0]  vind3;
    logic [13:0] evec3;

    int          mode;
    logic [4:0]  mask [512];
    int          n_checks = 0;
    int          n_pass = 0;
    logic [13:0] got_q [$];
    logic [13:0] exp_q [$];
    int          exp_errs;
    int          consec_bad = 0;
    logic        ev_prev = 1'b0;

    somador4_bist #(.SETTLE(1)) u_dut1 (
        .clk(clk), .rst(rst1), .start(start1), .A_o(a1), .B_o(b1), .CIN_o(c1),
        .S_i(s1), .COUT_i(co1), .busy(busy1), .done(done1), .pass(pass1), .erros(erros1),
        .vec_ind(vind1), .err_valid(ev1), .err_vec(evec1)
    );

    somador4_bist #(.SETTLE(3)) u_dut3 (
        .clk(clk), .rst(rst3), .start(start3), .A_o(a3), .B_o(b3), .CIN_o(c3),
        .S_i(s3), .COUT_i(co3), .busy(busy3), .done(done3), .pass(pass3), .erros(erros3),
        .vec_ind(vind3), .err_valid(ev3), .err_vec(evec3)
    );

    // Adder response {cout,s} for vector idx under fault mode m.
    function automatic logic [4:0] resp(input int idx, input int m);
        int a, b, c;
        logic [4:0] r;
        a = (idx >> 5) & 15;
        b = (idx >> 1) & 15;
        c = idx & 1;
        r = 5'(a + b + c);
        case (m)
            1: r[4] = 1'b0;
            2: r[0] = 1'b0;
            3: r = r ^ mask[idx];
            default: ;
        endcase
        return r;
    endfunction

    assign {co1, s1} = resp(int'({a1, b1, c1}), mode);
    assign {co3, s3} = resp(int'({a3, b3, c3}), 0);

    always @(negedge clk) begin
        if (ev1) got_q.push_back(evec1);
        if (ev1 && ev_prev) consec_bad++;
        ev_prev = ev1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic build_expect(input int m);
        logic [4:0] r, t;
        exp_q.delete();
        exp_errs = 0;
        for (int i = 0; i < 512; i++) begin
            r = resp(i, m);
            t = 5'((i >> 5 & 15) + (i >> 1 & 15) + (i & 1));
            exp_errs += int'(r[3:0] != t[3:0]) + int'(r[4] != t[4]);
            if (r != t) exp_q.push_back({9'(i), r[3:0], r[4]});
        end
    endtask

    task automatic pulse_start1();
        @(posedge clk); #1 start1 = 1'b1;
        @(posedge clk); #1 start1 = 1'b0;
    endtask

    task automatic run1(input int m, input string tag);
        int cycles, busy_cnt, bad;
        mode = m;
        build_expect(m);
        got_q.delete();
        pulse_start1();
        check_eq({tag, "_start_done"}, 32'(done1), 32'd0);
        check_eq({tag, "_start_erros"}, 32'(erros1), 32'd0);
        check_eq({tag, "_start_busy"}, 32'(busy1), 32'd1);
        cycles = 0;
        busy_cnt = 0;
        while (!done1 && cycles < 5000) begin
            if (busy1) busy_cnt++;
            @(posedge clk); #1;
            cycles++;
        end
        repeat (2) @(posedge clk);
        #1;
        check_eq({tag, "_cycles"}, 32'(cycles), 32'd1024);
        check_eq({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd1024);
        check_eq({tag, "_done"}, 32'(done1), 32'd1);
        check_eq({tag, "_pass"}, 32'(pass1), 32'(exp_errs == 0));
        check_eq({tag, "_erros"}, 32'(erros1), 32'(exp_errs));
        check_eq({tag, "_vec_ind"}, 32'(vind1), 32'd512);
        check_eq({tag, "_stim_hold"}, 32'({a1, b1, c1}), 32'd511);
        check_eq({tag, "_err_pulses"}, 32'(got_q.size()), 32'(exp_q.size()));
        bad = 0;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (got_q[i] !== exp_q[i]) bad++;
        check_eq({tag, "_err_vecs"}, 32'(bad), 32'd0);
    endtask

    initial begin
        int cycles, seg, hold_bad, seen;
        logic [8:0] prev;
        mode = 0;
        rst1 = 1'b0; rst3 = 1'b0; start1 = 1'b0; start3 = 1'b0;
        for (int i = 0; i < 512; i++) mask[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_outputs", 32'({a1, b1, c1, busy1, done1, pass1, ev1}), 32'd0);
        check_eq("reset_counts", 32'({erros1, vind1}), 32'd0);
        check_eq("reset_errvec", 32'(evec1), 32'd0);
        rst1 = 1'b1; rst3 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("idle_no_start", 32'({busy1, done1}), 32'd0);

        run1(0, "good");
        run1(1, "cout_sa0");
        check_eq("cout_sa0_erros256", 32'(erros1), 32'd256);
        check_eq("cout_sa0_first", 32'(got_q.size() > 0 ? got_q[0] : 14'h3fff),
                 32'(14'b0000_1111_1_0000_0));
        run1(0, "restart");
        run1(2, "s0_sa0");
        check_eq("s0_sa0_pulses256", 32'(got_q.size()), 32'd256);
        for (int k = 0; k < 20; k++) mask[$urandom_range(511)] = 5'($urandom_range(31, 1));
        run1(3, "random");
        check_eq("err_valid_single", 32'(consec_bad), 32'd0);

        // Reset in the middle of a run.
        mode = 0;
        pulse_start1();
        cycles = 0;
        while (vind1 != 10'd200 && cycles < 2000) begin
            @(posedge clk); #1;
            cycles++;
        end
        check_eq("reach_vec200", 32'(vind1), 32'd200);
        rst1 = 1'b0;
        @(posedge clk); #1;
        rst1 = 1'b1;
        check_eq("midreset_outputs", 32'({a1, b1, c1, busy1, done1, pass1, ev1}), 32'd0);
        check_eq("midreset_counts", 32'({erros1, vind1, evec1}), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("midreset_idle", 32'({busy1, done1, vind1}), 32'd0);
        run1(0, "after_reset");

        // SETTLE=3 run with an ignored second start.
        @(posedge clk); #1 start3 = 1'b1;
        @(posedge clk); #1 start3 = 1'b0;
        cycles = 0; hold_bad = 0; seen = 0; seg = 1;
        prev = {a3, b3, c3};
        while (!done3 && cycles < 10000) begin
            start3 = (cycles == 100);
            @(posedge clk); #1;
            cycles++;
            if ({a3, b3, c3} != prev) begin
                if (seen != 0 && seg != 4) hold_bad++;
                seen = 1;
                seg = 1;
                prev = {a3, b3, c3};
            end else begin
                seg++;
            end
        end
        start3 = 1'b0;
        check_eq("s3_cycles", 32'(cycles), 32'd2048);
        check_eq("s3_hold4", 32'(hold_bad), 32'd0);
        check_eq("s3_pass", 32'({done3, pass3}), 32'd3);
        check_eq("s3_counts", 32'({erros3, vind3}), 32'd512);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/somador4_bist.md
# somador4_bist

Hardware built-in self-test controller for the `somador4` 4-bit adder. It plays the source side of the adder's test-vector protocol: it generates every `{A,B,CIN}` stimulus in order and drives it into the adder. It also computes the expected `{S,COUT}` internally, samples the adder's response and counts mismatches. It sits beside a `somador4` instance and makes exhaustive adder checking available on silicon/FPGA, with no vector file.

## Interface
Parameters:
- `SETTLE`, default 1: cycles between driving a vector and sampling the response. Legal range 1..15.

Ports:
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst`  in  1: reset, synchronous, active-low.
- `start`  in  1: begins a full run. Sampled only in IDLE or DONE.
- `A_o`  out  4: stimulus A to the adder.
- `B_o`  out  4: stimulus B to the adder.
- `CIN_o`  out  1: stimulus carry-in to the adder.
- `S_i`  in  4: adder sum response.
- `COUT_i`  in  1: adder carry-out response.
- `busy`  out  1: high while a run is in progress.
- `done`  out  1: high from run completion until the next start or reset.
- `pass`  out  1: equals `done && erros==0`.
- `erros`  out  11: error count. Each S mismatch adds 1 and each COUT mismatch adds 1, so the maximum is 1024.
- `vec_ind`  out  10: number of vectors checked so far (0..512).
- `err_valid`  out  1: one-cycle pulse per failing vector.
- `err_vec`  out  14: failing vector, `{A,B,CIN,S_i,COUT_i}` as sampled.

## Operation
- Vector i (0..511) maps to `{A_o,B_o,CIN_o} = i[8:0]`, where A is bits 8:5, B is bits 4:1 and CIN is bit 0.
- Expected result: `{COUT,S} = A + B + CIN`, computed at 5-bit width with no truncation before the compare.
- FSM states:
  - IDLE → WAIT: when `start` is high. On that edge, load vector 0 and clear `erros`, `vec_ind` and `done`. Set `busy=1` and the settle counter to `SETTLE-1`.
  - WAIT → CHECK: when the settle counter reaches 0. Otherwise decrement the counter.
  - CHECK (one edge), in order:
    - Compare `S_i` against expected S and `COUT_i` against expected COUT, and add 0, 1 or 2 to `erros`.
    - If either field mismatched, set `err_valid=1` for the next cycle and load `err_vec`.
    - Increment `vec_ind`.
    - If i=511, go to DONE. Otherwise load vector i+1, reload the settle counter and go to WAIT.
  - DONE: `busy=0`, `done=1`. Outputs `A_o/B_o/CIN_o` hold vector 511. `start` high → same action as from IDLE.
- `start` is ignored in WAIT and CHECK. `start` held high continuously restarts the run once per completion.
- Any unknown (X/Z) value on `S_i`/`COUT_i` in simulation counts as a mismatch. Use a case-inequality compare.
- `err_vec` holds its last value until the next error or reset.
- `erros` cannot overflow because 11 bits covers 1024. No saturation logic is needed.

## Timing
- Reset (`rst=0` at a rising edge) forces, from the next cycle:
  - state IDLE;
  - `A_o=B_o=0`, `CIN_o=0`;
  - `busy=0`, `done=0`, `pass=0`;
  - `erros=0`, `vec_ind=0`;
  - `err_valid=0`, `err_vec=0`.
- Reset applies in any state, including mid-run. The run is abandoned and no `done` is produced.
- Reset has priority over `start` in the same cycle.
- Per-vector cost is `SETTLE+1` cycles. Start edge to `done=1` takes `512*(SETTLE+1)` cycles.
- The stimulus for vector i is stable for `SETTLE+1` edges. The response is sampled at the last of these edges.
- `err_valid` is asserted in the cycle after the CHECK edge of the failing vector. It is never high for two consecutive cycles when `SETTLE>=1`.
- `vec_ind` and `erros` are updated at the same edge, so both are valid together. When `done` rises, `vec_ind=512`.

## Test plan
- Correct `somador4` connected, `SETTLE=1`, pulse `start`:
  - `busy` is high for 1024 cycles.
  - Then `done=1`, `pass=1`, `erros=0`, `vec_ind=512`, and no `err_valid` pulse occurs.
- `COUT_i` stuck at 0:
  - Final `erros=256` and `pass=0`.
  - The first `err_valid` carries `err_vec = 0000_1111_1_0000_0` (i=31).
- `S_i[0]` stuck at 0: final `erros=256` and 256 `err_valid` pulses.
- `SETTLE=3`:
  - `done` rises 2048 cycles after the start edge.
  - Each vector is held for 4 cycles.
  - A second `start` while `busy` is ignored, so the run length is unchanged.
- Reset mid-run: drop `rst` for one cycle at `vec_ind=200`.
  - All outputs return to 0 and the state is IDLE.
  - A new `start` runs from vector 0 and completes with `pass=1`.
- Restart from DONE:
  - After a failing run (`erros=256`), swap in a correct adder and pulse `start`.
  - `done` drops and `erros` clears at the start edge.
  - The run completes with `pass=1`.
